matmul_2x2_host: RTL and testbench
==================================

# matmul_2x2_host

Initiator-side front end for the 2x2 matrix multiplier core. Accepts eight 16-bit operand words over a valid/ready stream, presents them to the core, runs the core's start/busy/done handshake, captures the four 32-bit products and streams them out over a valid/ready stream. Sits between the command/data fabric and the multiplier core, so the fabric never touches the core's level-sensitive handshake directly.

## Interface
- `TIMEOUT`, default 64: maximum cycles spent in ISSUE+WAIT before the job is aborted (watchdog builds only).
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1, `in_ready` out 1, `in_data` in 16: operand stream in the order a00, a01, a10, a11, b00, b01, b10, b11.
- `mm_a00`, `mm_a01`, `mm_a10`, `mm_a11`, `mm_b00`, `mm_b01`, `mm_b10`, `mm_b11` out 16 each: registered operands to the core.
- `mm_start` out 1: registered start level to the core.
- `mm_busy` in 1, `mm_done` in 1: core status.
- `mm_c00`, `mm_c01`, `mm_c10`, `mm_c11` in 32 each: core results.
- `out_valid` out 1, `out_ready` in 1, `out_data` out 32, `out_last` out 1: result stream in the order c00, c01, c10, c11; `out_last` is high on c11 only.
- `jobs_done` out 16: count of completed jobs, wraps 0xFFFF→0.
- `err_timeout` out 1: sticky abort flag.

## Operation
- States: LOAD, ISSUE, WAIT, DRAIN.
- LOAD: `in_ready`=1. Each accepted beat (`in_valid`&`in_ready`) writes operand register `idx` (3-bit, 0..7), then `idx`++. Accepting beat 7 sets `idx`=0 and moves to ISSUE with `mm_start`=1.
- ISSUE: `mm_start` held at 1. Leave for WAIT on the first cycle `mm_busy`=1. `mm_done` is ignored here because it is stale high from the previous job until the core accepts start.
- WAIT: `mm_start` held at 1. When `mm_done`=1: capture all four `mm_c*` into result registers, set `mm_start`=0, set `jobs_done`++, clear the result pointer, and go to DRAIN.
- DRAIN: `out_valid`=1, `out_data`=result[ptr], `out_last`=(ptr==3). Each handshake increments ptr. The handshake at ptr==3 returns to LOAD.
- Operand registers change only in LOAD, so the `mm_*` operands are stable through ISSUE and WAIT.
- The result registers are independent of `mm_c*` after capture.
- `out_ready`=0 stalls DRAIN indefinitely. `out_data` and `out_last` are held stable while stalled.
- `in_valid` outside LOAD is ignored, because `in_ready`=0.
- `err_timeout` is cleared on entry to ISSUE and set only by the watchdog.

## Timing
- Reset values: `in_ready`=0 during reset and 1 on the first cycle after release (state LOAD). `mm_start`=0; all `mm_*` operands=0; `out_valid`=0; `out_data`=0; `out_last`=0; `jobs_done`=0; `err_timeout`=0; `idx`=0; ptr=0.
- Reset asserted mid-job takes effect immediately:
  - `mm_start` drops asynchronously and the partial operand load is discarded.
  - The core returns to idle through its own start-low path or its own reset.
- Latency with the current core, where T is the edge that accepts beat 7:
  - `mm_start`=1 after T.
  - The core raises busy after T+1; the host enters WAIT at T+2.
  - The core raises done after T+3; the host captures at T+4.
  - `out_valid` is high after T+4, and `mm_start`=0 after T+4.
- Minimum job period is 8 (load) + 4 + 4 (drain) = 16 cycles with no backpressure.
- The returning handshake (the DRAIN→LOAD edge) and the first `in_valid` beat of the next job cannot overlap. `in_ready` rises the cycle after the last output handshake.

## Configuration
- `MM_HOST_TIMEOUT_EN` defined:
  - An 8-bit cycle counter clears on entry to ISSUE and increments each cycle in ISSUE or WAIT.
  - When the counter reaches `TIMEOUT`: drop `mm_start`, set `err_timeout`=1, leave `jobs_done` unchanged, discard the results, and return to LOAD.
- `MM_HOST_TIMEOUT_EN` undefined:
  - No counter exists; ISSUE and WAIT wait forever.
  - `err_timeout` is tied to 0.
  - `TIMEOUT` is unused.

## Test plan
- Basic job: stream A=[1,2,3,4], B=[5,6,7,8] with `out_ready`=1 → `out_data` sequence 19, 22, 43, 50; `out_last` only on 50; `jobs_done`=1; first `out_valid` 4 cycles after the beat-7 edge.
- Stale done: run two back-to-back jobs, the second with A=I, B=[9,8,7,6] → the second job does not complete before the core's busy rises; output is 9, 8, 7, 6; `jobs_done`=2.
- Backpressure: hold `out_ready`=0 for 10 cycles in DRAIN, then toggle it every other cycle → each word is held stable, none is lost or duplicated, and `in_ready` stays 0 until c11 is accepted.
- Max operands: all inputs 0xFFFF → every output is 0x1FFFC0002 truncated to 32 bits, i.e. 0xFFFC0002.
- Reset mid-op: assert `rst_n`=0 in WAIT → `mm_start`, `out_valid` and `jobs_done` are 0 immediately; after release, a full fresh job produces correct results.
- Watchdog (`MM_HOST_TIMEOUT_EN`, `TIMEOUT`=16): tie `mm_busy`=0 → after 16 cycles in ISSUE, `err_timeout`=1, `mm_start`=0 and `in_ready`=1; the next successful job clears `err_timeout`.

Source files
------------

// File: rtl/matmul_2x2_host_if.sv
// Operand and result streams between the command/data fabric and the 2x2 matmul host.
// Latency: none, wires only.
// Backpressure: valid/ready on both streams; the master drives in_* and out_ready.
interface matmul_2x2_host_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;

  // Fabric side: sources operands, sinks results
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  // Host side: sinks operands, sources results
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/matmul_2x2_host.sv
// Initiator front end for the 2x2 matmul core: load 8 operands, run start/busy/done, drain 4 results.
// Latency: first result valid 4 cycles after the 8th operand beat with the current core; 16-cycle min job period.
// Backpressure: in_ready only in LOAD; out_ready low stalls DRAIN with out_data/out_last held.
// Optional watchdog: define MM_HOST_TIMEOUT_EN to abort a job after TIMEOUT cycles in ISSUE+WAIT.
module matmul_2x2_host #(
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  matmul_2x2_host_if.slave   bus,
  output logic [15:0]        mm_a00,
  output logic [15:0]        mm_a01,
  output logic [15:0]        mm_a10,
  output logic [15:0]        mm_a11,
  output logic [15:0]        mm_b00,
  output logic [15:0]        mm_b01,
  output logic [15:0]        mm_b10,
  output logic [15:0]        mm_b11,
  output logic               mm_start,
  input  logic               mm_busy,
  input  logic               mm_done,
  input  logic [31:0]        mm_c00,
  input  logic [31:0]        mm_c01,
  input  logic [31:0]        mm_c10,
  input  logic [31:0]        mm_c11,
  output logic [15:0]        jobs_done,
  output logic               err_timeout
);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] opnd_q [8];
  logic [15:0] opnd_d [8];
  logic [31:0] res_q [4];
  logic [31:0] res_d [4];
  logic [1:0]  ptr_q, ptr_d;
  logic        start_q, start_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_last_q, out_last_d;
  logic [15:0] jobs_q, jobs_d;

`ifdef MM_HOST_TIMEOUT_EN
  logic [7:0]  tmo_q, tmo_d;
  logic        err_q, err_d;
`else
  logic [7:0]  unused_timeout;
  assign unused_timeout = 8'(TIMEOUT);
`endif

  // Next-state and next-output logic for the load/issue/wait/drain sequence
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    opnd_d      = opnd_q;
    res_d       = res_q;
    ptr_d       = ptr_q;
    start_d     = start_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    jobs_d      = jobs_q;
`ifdef MM_HOST_TIMEOUT_EN
    tmo_d       = tmo_q;
    err_d       = err_q;
`endif

    case (state_q)
      S_LOAD: begin
        if (in_ready_q && bus.in_valid) begin
          opnd_d[idx_q] = bus.in_data;
          if (idx_q == 3'd7) begin
            idx_d   = 3'd0;
            start_d = 1'b1;
            state_d = S_ISSUE;
`ifdef MM_HOST_TIMEOUT_EN
            tmo_d   = 8'd0;
            err_d   = 1'b0;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end

      // done is still high from the previous job here; only busy proves the core took start
      S_ISSUE: begin
        if (mm_busy) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (mm_done) begin
          res_d       = '{mm_c00, mm_c01, mm_c10, mm_c11};
          start_d     = 1'b0;
          jobs_d      = jobs_q + 16'd1;
          ptr_d       = 2'd0;
          out_valid_d = 1'b1;
          out_data_d  = mm_c00;
          out_last_d  = 1'b0;
          state_d     = S_DRAIN;
        end
      end

      S_DRAIN: begin
        if (bus.out_ready) begin
          if (ptr_q == 2'd3) begin
            ptr_d       = 2'd0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            state_d     = S_LOAD;
          end else begin
            ptr_d      = ptr_q + 2'd1;
            out_data_d = res_q[ptr_d];
            out_last_d = (ptr_d == 2'd3);
          end
        end
      end

      default: state_d = S_LOAD;
    endcase

`ifdef MM_HOST_TIMEOUT_EN
    // A completion on the same cycle the watchdog would fire wins over the abort
    if (state_q == S_ISSUE || state_q == S_WAIT) begin
      tmo_d = tmo_q + 8'd1;
      if (tmo_d == 8'(TIMEOUT) && !(state_q == S_WAIT && mm_done)) begin
        state_d = S_LOAD;
        start_d = 1'b0;
        err_d   = 1'b1;
      end
    end
`endif

    // Registered so in_ready rises only the cycle after the final result handshake
    in_ready_d = (state_d == S_LOAD);
  end

  // State and output registers; reset drops mm_start and discards any partial load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_LOAD;
      idx_q       <= '0;
      opnd_q      <= '{default: '0};
      res_q       <= '{default: '0};
      ptr_q       <= '0;
      start_q     <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      jobs_q      <= '0;
`ifdef MM_HOST_TIMEOUT_EN
      tmo_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      opnd_q      <= opnd_d;
      res_q       <= res_d;
      ptr_q       <= ptr_d;
      start_q     <= start_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      jobs_q      <= jobs_d;
`ifdef MM_HOST_TIMEOUT_EN
      tmo_q       <= tmo_d;
      err_q       <= err_d;
`endif
    end
  end

  assign mm_a00        = opnd_q[0];
  assign mm_a01        = opnd_q[1];
  assign mm_a10        = opnd_q[2];
  assign mm_a11        = opnd_q[3];
  assign mm_b00        = opnd_q[4];
  assign mm_b01        = opnd_q[5];
  assign mm_b10        = opnd_q[6];
  assign mm_b11        = opnd_q[7];
  assign mm_start      = start_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign jobs_done     = jobs_q;
`ifdef MM_HOST_TIMEOUT_EN
  assign err_timeout   = err_q;
`else
  assign err_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_matmul_2x2_host.sv
// Bench for matmul_2x2_host: core stub, randomized jobs, matrix-product scoreboard.
// Latency: checks first result 4 cycles after the 8th beat when unstalled.
// Backpressure: drives random and scripted out_ready stalls and checks hold/ordering.
module tb_matmul_2x2_host;
  logic        clk;
  logic        rst_n;
  logic [15:0] mm_a00, mm_a01, mm_a10, mm_a11, mm_b00, mm_b01, mm_b10, mm_b11;
  logic        mm_start, mm_busy, mm_done;
  logic [31:0] mm_c00, mm_c01, mm_c10, mm_c11;
  logic [15:0] jobs_done;
  logic        err_timeout;

  matmul_2x2_host_if bus();

  matmul_2x2_host #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .mm_a00(mm_a00), .mm_a01(mm_a01), .mm_a10(mm_a10), .mm_a11(mm_a11),
    .mm_b00(mm_b00), .mm_b01(mm_b01), .mm_b10(mm_b10), .mm_b11(mm_b11),
    .mm_start(mm_start), .mm_busy(mm_busy), .mm_done(mm_done),
    .mm_c00(mm_c00), .mm_c01(mm_c01), .mm_c10(mm_c10), .mm_c11(mm_c11),
    .jobs_done(jobs_done), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_jobs = 0;
  int flush_req = 0;
  logic [31:0] got [$];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  // Reference: C = A x B, row-major words a00,a01,a10,a11,b00,b01,b10,b11
  function automatic logic [31:0] mm_ref(input logic [15:0] w [8], input int k);
    logic [33:0] s;
    int i, j;
    i = k / 2;
    j = k % 2;
    s = 34'(w[2*i]) * 34'(w[4+j]) + 34'(w[2*i+1]) * 34'(w[6+j]);
    return s[31:0];
  endfunction

  // Core stub: busy 2 cycles after accepting start, done stays high until next start,
  // results scrambled once start drops so a late capture would be caught
  logic       core_hang;
  logic [1:0] core_cnt;
  logic       core_armed;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mm_busy <= 1'b0; mm_done <= 1'b0; core_armed <= 1'b1; core_cnt <= 2'd0;
      mm_c00 <= '0; mm_c01 <= '0; mm_c10 <= '0; mm_c11 <= '0;
    end else if (mm_busy) begin
      if (core_cnt == 2'd1) begin
        mm_busy <= 1'b0;
        mm_done <= 1'b1;
        mm_c00  <= 32'(mm_a00) * 32'(mm_b00) + 32'(mm_a01) * 32'(mm_b10);
        mm_c01  <= 32'(mm_a00) * 32'(mm_b01) + 32'(mm_a01) * 32'(mm_b11);
        mm_c10  <= 32'(mm_a10) * 32'(mm_b00) + 32'(mm_a11) * 32'(mm_b10);
        mm_c11  <= 32'(mm_a10) * 32'(mm_b01) + 32'(mm_a11) * 32'(mm_b11);
      end else begin
        core_cnt <= core_cnt + 2'd1;
      end
    end else if (mm_start && core_armed && !core_hang) begin
      mm_busy <= 1'b1; mm_done <= 1'b0; core_cnt <= 2'd0; core_armed <= 1'b0;
    end else if (!mm_start) begin
      core_armed <= 1'b1;
      if (mm_done) begin
        mm_c00 <= $urandom; mm_c01 <= $urandom; mm_c10 <= $urandom; mm_c11 <= $urandom;
      end
    end
  end

  // Compare process: collects accepted beats into the model and checks every meaningful cycle
  logic [15:0] beat_buf [8];
  logic [15:0] ops [8];
  int          nb = 0;
  logic        ops_ok = 1'b0;
  logic [31:0] exp_d [$];
  logic        exp_l [$];
  logic        stall_v = 1'b0;
  logic [31:0] stall_d;
  logic        stall_l;
  int          flush_seen = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      nb = 0; ops_ok = 1'b0; stall_v = 1'b0;
      exp_d.delete(); exp_l.delete();
    end else begin
      if (flush_seen != flush_req) begin
        exp_d.delete(); exp_l.delete(); ops_ok = 1'b0;
        flush_seen = flush_req;
      end
      if (bus.in_valid && bus.in_ready) begin
        beat_buf[nb] = bus.in_data;
        nb++;
        if (nb == 8) begin
          for (int k = 0; k < 4; k++) begin
            exp_d.push_back(mm_ref(beat_buf, k));
            exp_l.push_back(k == 3);
          end
          ops = beat_buf;
          ops_ok = 1'b1;
          nb = 0;
        end
      end
      if (mm_start && ops_ok)
        check("operands", {mm_a00, mm_a01, mm_a10, mm_a11, mm_b00, mm_b01, mm_b10, mm_b11},
              {ops[0], ops[1], ops[2], ops[3], ops[4], ops[5], ops[6], ops[7]});
      if (bus.out_valid) begin
        check("in_ready_in_drain", 128'(bus.in_ready), 128'(0));
        if (stall_v) begin
          check("held_data", 128'(bus.out_data), 128'(stall_d));
          check("held_last", 128'(bus.out_last), 128'(stall_l));
        end
        if (bus.out_ready) begin
          stall_v = 1'b0;
          if (exp_d.size() == 0) begin
            fail("unexpected_output");
          end else begin
            check("out_data", 128'(bus.out_data), 128'(exp_d.pop_front()));
            check("out_last", 128'(bus.out_last), 128'(exp_l.pop_front()));
          end
          got.push_back(bus.out_data);
        end else begin
          stall_v = 1'b1;
          stall_d = bus.out_data;
          stall_l = bus.out_last;
        end
      end else begin
        stall_v = 1'b0;
      end
    end
  end

  // mode: 0 no stalls, 1 random gaps/stalls, 2 scripted stall, 3 reset in WAIT, 4 watchdog
  task automatic run_job(input logic [15:0] w [8], input int mode);
    logic hs, r;
    int g, cnt, n, c;
    bus.out_ready = (mode == 0);
    for (int i = 0; i < 8; i++) begin
      if (mode == 1) begin
        repeat ($urandom_range(0, 2)) begin
          bus.in_valid = 1'b0; bus.in_data = 16'($urandom);
          @(posedge clk); #1;
        end
      end
      bus.in_valid = 1'b1;
      bus.in_data  = w[i];
      g = 0;
      do begin
        hs = bus.in_ready;
        @(posedge clk); #1;
        g++;
      end while (!hs && g < 100);
      if (!hs) begin
        fail("load_accept");
        bus.in_valid = 1'b0;
        return;
      end
    end
    bus.in_valid = 1'b0;
    check("start_after_beat7", 128'(mm_start), 128'(1));

    if (mode == 3) begin
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_mm_start", 128'(mm_start), 128'(0));
      check("rst_out_valid", 128'(bus.out_valid), 128'(0));
      check("rst_jobs_done", 128'(jobs_done), 128'(0));
      check("rst_in_ready", 128'(bus.in_ready), 128'(0));
      check("rst_operands", {mm_a00, mm_a01, mm_a10, mm_a11, mm_b00, mm_b01, mm_b10, mm_b11}, 128'(0));
      exp_jobs = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_release_in_ready", 128'(bus.in_ready), 128'(1));
      return;
    end

    if (mode == 4) begin
      cnt = 0;
      while (!bus.in_ready && cnt < 200) begin
        @(posedge clk); #1;
        cnt++;
      end
      check("wd_cycles", 128'(cnt), 128'(16));
      check("wd_err", 128'(err_timeout), 128'(1));
      check("wd_start", 128'(mm_start), 128'(0));
      check("wd_jobs", 128'(jobs_done), 128'(exp_jobs));
      flush_req++;
      return;
    end

    cnt = 0;
    while (!bus.out_valid && cnt < 200) begin
      if (mode == 1) begin
        bus.in_valid = 1'($urandom); bus.in_data = 16'($urandom);
      end
      @(posedge clk); #1;
      cnt++;
    end
    if (!bus.out_valid) begin
      fail("wait_out_valid");
      bus.in_valid = 1'b0;
      return;
    end
    if (mode == 0) begin
      check("latency", 128'(cnt), 128'(4));
      check("start_dropped", 128'(mm_start), 128'(0));
    end

    n = 0;
    c = 0;
    while (n < 4 && c < 300) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = 1'($urandom);
        default: r = (c >= 10) && (c % 2 == 0);
      endcase
      if (mode == 1) begin
        bus.in_valid = 1'($urandom); bus.in_data = 16'($urandom);
      end
      bus.out_ready = r;
      hs = bus.out_valid && r;
      @(posedge clk); #1;
      c++;
      if (hs) n++;
    end
    bus.in_valid = 1'b0;
    if (n < 4) begin
      fail("drain");
      return;
    end
    exp_jobs++;
    check("in_ready_after_drain", 128'(bus.in_ready), 128'(1));
    check("jobs_done", 128'(jobs_done), 128'(exp_jobs));
  endtask

  task automatic pin(input int base, input logic [31:0] e0, input logic [31:0] e1,
                     input logic [31:0] e2, input logic [31:0] e3);
    if (got.size() < base + 4) begin
      fail("pin_count");
      return;
    end
    check("pin_c00", 128'(got[base]),   128'(e0));
    check("pin_c01", 128'(got[base+1]), 128'(e1));
    check("pin_c10", 128'(got[base+2]), 128'(e2));
    check("pin_c11", 128'(got[base+3]), 128'(e3));
  endtask

  initial begin
    logic [15:0] w [8];
    int base;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    core_hang = 1'b0;
    #12;
    check("reset_in_ready", 128'(bus.in_ready), 128'(0));
    check("reset_mm_start", 128'(mm_start), 128'(0));
    check("reset_out", {bus.out_valid, bus.out_last, bus.out_data}, 128'(0));
    check("reset_jobs_err", {jobs_done, err_timeout}, 128'(0));
    check("reset_operands", {mm_a00, mm_a01, mm_a10, mm_a11, mm_b00, mm_b01, mm_b10, mm_b11}, 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("release_in_ready", 128'(bus.in_ready), 128'(1));

    w = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    base = got.size();
    run_job(w, 0);
    pin(base, 32'd19, 32'd22, 32'd43, 32'd50);

    w = '{16'd1, 16'd0, 16'd0, 16'd1, 16'd9, 16'd8, 16'd7, 16'd6};
    base = got.size();
    run_job(w, 0);
    pin(base, 32'd9, 32'd8, 32'd7, 32'd6);
    check("jobs_two", 128'(jobs_done), 128'(2));

    for (int i = 0; i < 8; i++) w[i] = 16'($urandom);
    run_job(w, 2);

    w = '{default: 16'hFFFF};
    base = got.size();
    run_job(w, 0);
    pin(base, 32'hFFFC0002, 32'hFFFC0002, 32'hFFFC0002, 32'hFFFC0002);

    repeat (8) begin
      for (int i = 0; i < 8; i++) w[i] = 16'($urandom);
      run_job(w, 1);
    end
    check("err_clear_default", 128'(err_timeout), 128'(0));

    for (int i = 0; i < 8; i++) w[i] = 16'($urandom);
    run_job(w, 3);
    w = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    base = got.size();
    run_job(w, 0);
    pin(base, 32'd19, 32'd22, 32'd43, 32'd50);
    check("jobs_after_reset", 128'(jobs_done), 128'(1));

`ifdef MM_HOST_TIMEOUT_EN
    core_hang = 1'b1;
    for (int i = 0; i < 8; i++) w[i] = 16'($urandom);
    run_job(w, 4);
    core_hang = 1'b0;
    w = '{16'd1, 16'd0, 16'd0, 16'd1, 16'd9, 16'd8, 16'd7, 16'd6};
    base = got.size();
    run_job(w, 0);
    pin(base, 32'd9, 32'd8, 32'd7, 32'd6);
    check("wd_err_cleared", 128'(err_timeout), 128'(0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end
endmodule
